videomem_wr_req: RTL

- Writer-side counterpart of the video memory read-request generator.
- Collects pixel words arriving from the USB/host side into an 8-word burst buffer.
- Issues burst write requests to the memory controller at frame-buffer addresses laid out as {line, burst index, 3'b000}.
- Frame-start marker realigns the address to zero; one buffer, fill -> request -> drain.

---
 rtl/videomem_wr_req.sv | 125 ++++++++++++
 1 files changed

// File: rtl/videomem_wr_req.sv
// videomem_wr_req: buffers host pixel words into 8-word bursts and issues frame-buffer write requests.
// Ports: mem_clock/reset_n (async active-low); in_data/in_valid/in_sof/in_ready host stream;
// mem_ready/write_request/write_req_ack/write_addr request handshake; wdata/wdata_valid burst data;
// frame_done pulse at the last burst ack of a frame; sof_drop pulse when in_sof discards a partial buffer.
module videomem_wr_req #(
    parameter int DATA_W         = 16,
    parameter int BURST_LEN      = 8,
    parameter int MAX_NUM_HWRITE = 160,
    parameter int LINE_NUM       = 720
) (
    input  logic              mem_clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    input  logic              mem_ready,
    output logic              write_request,
    input  logic              write_req_ack,
    output logic [24:0]       write_addr,
    output logic [DATA_W-1:0] wdata,
    output logic              wdata_valid,
    output logic              frame_done,
    output logic              sof_drop
);
    typedef enum logic [1:0] {FILL, REQ, DATA} state_t;
    state_t            state_q, state_d;
    logic [2:0]        fill_q, fill_d;
    logic [DATA_W-1:0] burst_q [BURST_LEN];
    logic [DATA_W-1:0] burst_d [BURST_LEN];
    logic [12:0]       lines_q, lines_d;
    logic [8:0]        hw_q, hw_d;
    logic              in_ready_q, in_ready_d;
    logic              write_request_q, write_request_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wdata_valid_q, wdata_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              sof_drop_q, sof_drop_d;
    logic              last_hw, last_line;
    assign last_hw   = hw_q == 9'(MAX_NUM_HWRITE - 1);
    assign last_line = lines_q == 13'(LINE_NUM - 1);
    always_comb begin
        state_d         = state_q;
        fill_d          = fill_q;
        burst_d         = burst_q;
        lines_d         = lines_q;
        hw_d            = hw_q;
        write_request_d = 1'b0;
        wdata_d         = wdata_q;
        wdata_valid_d   = 1'b0;
        frame_done_d    = 1'b0;
        sof_drop_d      = 1'b0;
        case (state_q)
            FILL: if (in_valid && in_ready_q) begin
                if (in_sof) begin
                    burst_d[0] = in_data;
                    fill_d     = 3'd1;
                    lines_d    = '0;
                    hw_d       = '0;
                    sof_drop_d = fill_q != 3'd0;
                end else begin
                    burst_d[fill_q] = in_data;
                    fill_d          = fill_q + 3'd1;
                    state_d         = fill_q == 3'd7 ? REQ : FILL;
                end
            end
            REQ: if (write_request_q && write_req_ack) begin
                // word 0 is launched on the ack so wdata_valid starts the very next cycle
                state_d       = DATA;
                wdata_d       = burst_q[0];
                wdata_valid_d = 1'b1;
                fill_d        = 3'd1;
                frame_done_d  = last_hw && last_line;
            end else begin
                write_request_d = mem_ready;
            end
            // fill_q doubles as the drain index; wrapping back to 0 marks the cycle the 8th word is on the bus
            DATA: if (fill_q == 3'd0) begin
                state_d = FILL;
                hw_d    = last_hw ? 9'd0 : hw_q + 9'd1;
                lines_d = last_hw ? (last_line ? 13'd0 : lines_q + 13'd1) : lines_q;
            end else begin
                wdata_d       = burst_q[fill_q];
                wdata_valid_d = 1'b1;
                fill_d        = fill_q + 3'd1;
            end
            default: state_d = FILL;
        endcase
        in_ready_d = state_d == FILL;
    end
    always_ff @(posedge mem_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= FILL;
            fill_q          <= '0;
            burst_q         <= '{default: '0};
            lines_q         <= '0;
            hw_q            <= '0;
            in_ready_q      <= 1'b0;
            write_request_q <= 1'b0;
            wdata_q         <= '0;
            wdata_valid_q   <= 1'b0;
            frame_done_q    <= 1'b0;
            sof_drop_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            fill_q          <= fill_d;
            burst_q         <= burst_d;
            lines_q         <= lines_d;
            hw_q            <= hw_d;
            in_ready_q      <= in_ready_d;
            write_request_q <= write_request_d;
            wdata_q         <= wdata_d;
            wdata_valid_q   <= wdata_valid_d;
            frame_done_q    <= frame_done_d;
            sof_drop_q      <= sof_drop_d;
        end
    end
    assign in_ready      = in_ready_q;
    assign write_request = write_request_q;
    assign write_addr    = {lines_q, hw_q, 3'b000};
    assign wdata         = wdata_q;
    assign wdata_valid   = wdata_valid_q;
    assign frame_done    = frame_done_q;
    assign sof_drop      = sof_drop_q;
endmodule
